// File: rtl/adc_spi_scheduler.sv
// adc_spi_scheduler
//   Owns the serial ADC link and shares it between two requesters with
//   round-robin arbitration. Each grant runs one 16-bit frame (16 sck rising
//   edges, MSB first) and returns the low 12 bits to the granted requester,
//   together with a leading-bits error flag and an unsigned threshold compare.
//
// Parameters
//   CLK_DIV    sck half-period in clk cycles (>=1)
//   QUIET      clk cycles cs stays high after a frame before the next grant (>=1)
//
// Ports
//   clk, rst_n   system clock, asynchronous active-low reset
//   req[1:0]     level requests, held until the matching ack
//   ack[1:0]     one-cycle pulse to the granted requester when data is valid
//   owner        requester granted for the current or last frame
//   data[11:0]   last sample (low 12 bits of the frame)
//   data_valid   one-cycle pulse, coincident with ack
//   frame_err    leading 4 frame bits were not zero
//   threshold    compare value, sampled at frame end
//   above        data > threshold (unsigned), updated with data
//   cs, sck      ADC chip select (active low) and serial clock (idle high)
//   sdo          ADC serial data, changes after falling sck

module adc_spi_scheduler #(
    parameter int CLK_DIV = 2,
    parameter int QUIET   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    output logic [1:0]  ack,
    output logic        owner,
    output logic [11:0] data,
    output logic        data_valid,
    output logic        frame_err,
    input  logic [11:0] threshold,
    output logic        above,
    output logic        cs,
    output logic        sck,
    input  logic        sdo
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } state_t;

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int Q_W   = (QUIET > 1) ? $clog2(QUIET) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [Q_W-1:0]   Q_LAST   = Q_W'(QUIET - 1);

    state_t           state;
    logic [DIV_W-1:0] div_cnt;   // clk cycles within the current sck half-period
    logic [Q_W-1:0]   q_cnt;     // clk cycles spent in HOLD
    logic [5:0]       edge_cnt;  // sck toggles issued so far in this frame
    logic [15:0]      shift;
    logic             prefer;    // requester favoured when both request

    logic grant_idx;
    logic start_frame;

    always_comb begin
        grant_idx = 1'b0;
        case (req)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = prefer;
            default: grant_idx = 1'b0;
        endcase
        // The last HOLD cycle arbitrates like IDLE so that the next grant edge
        // lands exactly QUIET cycles after frame end while HOLD still spans
        // QUIET full cycles of cs high.
        start_frame = (|req) &&
                      ((state == IDLE) || ((state == HOLD) && (q_cnt == Q_LAST)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            div_cnt    <= '0;
            q_cnt      <= '0;
            edge_cnt   <= '0;
            shift      <= '0;
            prefer     <= 1'b0;
            ack        <= '0;
            owner      <= 1'b0;
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            above      <= 1'b0;
            cs         <= 1'b1;
            sck        <= 1'b1;
        end else begin
            ack        <= '0;
            data_valid <= 1'b0;

            case (state)
                IDLE: begin
                    cs  <= 1'b1;
                    sck <= 1'b1;
                end

                SETUP: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= '0;
                        sck      <= 1'b0;
                        edge_cnt <= 6'd1;
                        state    <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (edge_cnt != 6'd32) begin
                            sck      <= ~sck;
                            edge_cnt <= edge_cnt + 6'd1;
                            // sck currently low: this edge is a rising edge
                            if (!sck) begin
                                shift <= {shift[14:0], sdo};
                            end
                        end else begin
                            cs         <= 1'b1;
                            sck        <= 1'b1;
                            data       <= shift[11:0];
                            frame_err  <= |shift[15:12];
                            above      <= (shift[11:0] > threshold);
                            ack        <= owner ? 2'b10 : 2'b01;
                            data_valid <= 1'b1;
                            q_cnt      <= '0;
                            state      <= HOLD;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                HOLD: begin
                    if (q_cnt == Q_LAST) begin
                        state <= IDLE;
                    end else begin
                        q_cnt <= q_cnt + 1'b1;
                    end
                end
            endcase

            if (start_frame) begin
                owner    <= grant_idx;
                prefer   <= ~grant_idx;
                cs       <= 1'b0;
                sck      <= 1'b1;
                div_cnt  <= '0;
                edge_cnt <= '0;
                state    <= SETUP;
            end
        end
    end

endmodule

// File: tb/tb_adc_spi_scheduler.sv
module tb_adc_spi_scheduler;

    localparam int CLK_DIV = 2;
    localparam int QUIET   = 4;
    localparam int FRAME   = 33 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [1:0]  ack;
    logic        owner;
    logic [11:0] data;
    logic        data_valid;
    logic        frame_err;
    logic [11:0] threshold = 12'h000;
    logic        above;
    logic        cs;
    logic        sck;
    logic        sdo = 1'b0;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [15:0] adc_word = 16'h0000;
    logic        model_prefer = 1'b0;

    adc_spi_scheduler #(
        .CLK_DIV(CLK_DIV),
        .QUIET  (QUIET)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .ack       (ack),
        .owner     (owner),
        .data      (data),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .threshold (threshold),
        .above     (above),
        .cs        (cs),
        .sck       (sck),
        .sdo       (sdo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: frame latched when cs falls, next bit driven after each falling sck.
    initial begin : adc_model
        logic [15:0] cur;
        int bitn;
        forever begin
            @(negedge cs);
            cur  = adc_word;
            bitn = 0;
            while (cs === 1'b0) begin
                @(negedge sck or posedge cs);
                if (cs === 1'b0 && bitn < 16) begin
                    sdo  = cur[15-bitn];
                    bitn = bitn + 1;
                end
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        req   = 2'b00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_prefer = 1'b0;
        @(negedge clk);
    endtask

    // Runs one frame with the given ADC word and observes it; returns at the
    // negedge where cs has returned high (the data_valid cycle).
    task automatic do_frame(input logic [15:0] word, output int g_cyc, output int a_cyc,
                            output logic [1:0] a_seen, output int rises, output int low_cyc,
                            output int stray);
        int   n;
        logic prev_sck;
        adc_word = word;
        g_cyc = 0; a_cyc = 0; a_seen = 2'b00; rises = 0; low_cyc = 0; stray = 0;
        n = 0;
        while (cs !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
            if (cs === 1'b1 && data_valid === 1'b1) stray++;
        end
        checks++;
        if (cs !== 1'b0) begin
            errors++;
            $display("FAIL grant_timeout: cs=%b after %0d cycles, required 0", cs, n);
            return;
        end
        g_cyc    = cyc;
        low_cyc  = 1;
        prev_sck = sck;
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (cs !== 1'b0) break;
            low_cyc++;
            if (sck === 1'b1 && prev_sck === 1'b0) rises++;
            prev_sck = sck;
        end
        checks++;
        if (cs !== 1'b1) begin
            errors++;
            $display("FAIL frame_timeout: cs=%b after %0d cycles, required 1", cs, n);
            return;
        end
        a_cyc  = cyc;
        a_seen = ack;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 2'b00;
        @(negedge clk);
        checks++;
        if ({cs, sck, ack, data_valid} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_pins: cs,sck,ack,dv=%b required 11000", {cs, sck, ack, data_valid});
        end
        checks++;
        if ({data, frame_err, above, owner} !== 15'h0) begin
            errors++;
            $display("FAIL reset_data: data=%h fe=%b above=%b owner=%b required all 0",
                     data, frame_err, above, owner);
        end
        rst_n = 1'b1;
        model_prefer = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({cs, sck, ack} !== 4'b1100) begin
            errors++;
            $display("FAIL idle_no_req: cs,sck,ack=%b required 1100", {cs, sck, ack});
        end
    endtask

    task automatic test_single();
        int g, a, r, l, s;
        logic [1:0] ak;
        do_reset();
        threshold = 12'hFFF;
        adc_word  = 16'h0ABC;
        req = 2'b01;
        @(negedge clk);
        req = 2'b00;  // pulse only; ack must still arrive
        do_frame(16'h0ABC, g, a, ak, r, l, s);
        checks++;
        if (a - g !== FRAME) begin
            errors++;
            $display("FAIL single_latency: got %0d cycles required %0d", a - g, FRAME);
        end
        checks++;
        if (ak !== 2'b01 || data_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_ack: ack=%b dv=%b required 01/1", ak, data_valid);
        end
        checks++;
        if (data !== 12'hABC || frame_err !== 1'b0 || owner !== 1'b0) begin
            errors++;
            $display("FAIL single_data: data=%h fe=%b owner=%b required abc/0/0", data, frame_err, owner);
        end
        checks++;
        if (l !== FRAME || r !== 16) begin
            errors++;
            $display("FAIL single_pins: cs_low=%0d rises=%0d required %0d/16", l, r, FRAME);
        end
        @(negedge clk);
        checks++;
        if (ack !== 2'b00 || data_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pulse_width: ack=%b dv=%b required 00/0", ack, data_valid);
        end
        for (int i = 0; i < QUIET + 4; i++) begin
            checks++;
            if (cs !== 1'b1 || sck !== 1'b1 || data !== 12'hABC) begin
                errors++;
                $display("FAIL single_hold: cs=%b sck=%b data=%h required 1/1/abc", cs, sck, data);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int g, a, r, l, s, prev_g;
        logic [1:0]  ak;
        logic [15:0] w;
        logic        exp_o;
        do_reset();
        req = 2'b11;
        prev_g = 0;
        for (int i = 0; i < 4; i++) begin
            w = 16'($urandom) & 16'h0FFF;
            do_frame(w, g, a, ak, r, l, s);
            if (i == 3) req = 2'b00;
            exp_o = model_prefer;
            model_prefer = ~exp_o;
            checks++;
            if (owner !== exp_o || ak !== (exp_o ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL b2b_grant[%0d]: owner=%b ack=%b required owner %b", i, owner, ak, exp_o);
            end
            checks++;
            if (data !== w[11:0]) begin
                errors++;
                $display("FAIL b2b_data[%0d]: data=%h required %h", i, data, w[11:0]);
            end
            if (i > 0) begin
                checks++;
                if (g - prev_g !== FRAME + QUIET) begin
                    errors++;
                    $display("FAIL b2b_spacing[%0d]: got %0d required %0d", i, g - prev_g, FRAME + QUIET);
                end
            end
            prev_g = g;
        end
    endtask

    task automatic test_rr_pointer();
        int g, a, r, l, s;
        logic [1:0] ak;
        do_reset();
        req = 2'b10;
        do_frame(16'h0111, g, a, ak, r, l, s);
        req = 2'b11;
        checks++;
        if (owner !== 1'b1 || ak !== 2'b10) begin
            errors++;
            $display("FAIL rr_first: owner=%b ack=%b required 1/10", owner, ak);
        end
        do_frame(16'h0222, g, a, ak, r, l, s);
        req = 2'b00;
        checks++;
        if (owner !== 1'b0 || ak !== 2'b01 || data !== 12'h222) begin
            errors++;
            $display("FAIL rr_second: owner=%b ack=%b data=%h required 0/01/222", owner, ak, data);
        end
        model_prefer = 1'b1;
    endtask

    task automatic test_frame_err();
        int g, a, r, l, s;
        logic [1:0] ak;
        req = 2'b01;
        do_frame(16'hF123, g, a, ak, r, l, s);
        req = 2'b00;
        checks++;
        if (data !== 12'h123 || frame_err !== 1'b1) begin
            errors++;
            $display("FAIL ferr_set: data=%h fe=%b required 123/1", data, frame_err);
        end
        repeat (QUIET + 2) @(negedge clk);
        checks++;
        if (frame_err !== 1'b1) begin
            errors++;
            $display("FAIL ferr_hold: fe=%b required 1", frame_err);
        end
        req = 2'b01;
        do_frame(16'h0123, g, a, ak, r, l, s);
        req = 2'b00;
        checks++;
        if (data !== 12'h123 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL ferr_clear: data=%h fe=%b required 123/0", data, frame_err);
        end
        model_prefer = 1'b1;
    endtask

    task automatic test_threshold();
        int g, a, r, l, s;
        logic [1:0] ak;
        threshold = 12'h800;
        req = 2'b01;
        do_frame(16'h0801, g, a, ak, r, l, s);
        req = 2'b00;
        checks++;
        if (above !== 1'b1) begin
            errors++;
            $display("FAIL thr_above: above=%b required 1", above);
        end
        req = 2'b01;
        do_frame(16'h0800, g, a, ak, r, l, s);
        req = 2'b00;
        checks++;
        if (above !== 1'b0) begin
            errors++;
            $display("FAIL thr_equal: above=%b required 0", above);
        end
        threshold = 12'h000;
        repeat (10) @(negedge clk);
        checks++;
        if (above !== 1'b0) begin
            errors++;
            $display("FAIL thr_between_frames: above=%b required 0", above);
        end
        req = 2'b01;
        do_frame(16'h0800, g, a, ak, r, l, s);
        req = 2'b00;
        checks++;
        if (above !== 1'b1) begin
            errors++;
            $display("FAIL thr_next_frame: above=%b required 1", above);
        end
        model_prefer = 1'b1;
    endtask

    task automatic test_random();
        int g, a, r, l, s;
        logic [1:0]  ak, rq, exp_ack;
        logic [15:0] w;
        logic [11:0] thr;
        logic        exp_o;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            rq  = 2'($urandom_range(1, 3));
            w   = 16'($urandom);
            thr = 12'($urandom);
            if (i % 4 == 0) w[15:12] = 4'h0;
            threshold = thr;
            req = rq;
            do_frame(w, g, a, ak, r, l, s);
            req = 2'b00;
            exp_o = (rq == 2'b11) ? model_prefer : (rq == 2'b10);
            model_prefer = ~exp_o;
            exp_ack = exp_o ? 2'b10 : 2'b01;
            checks++;
            if (owner !== exp_o || ak !== exp_ack || data_valid !== 1'b1) begin
                errors++;
                $display("FAIL rand_grant[%0d]: req=%b owner=%b ack=%b dv=%b required owner %b ack %b",
                         i, rq, owner, ak, data_valid, exp_o, exp_ack);
            end
            checks++;
            if (data !== w[11:0] || frame_err !== (w[15:12] != 4'h0) || above !== (w[11:0] > thr)) begin
                errors++;
                $display("FAIL rand_data[%0d]: data=%h fe=%b above=%b required %h/%b/%b",
                         i, data, frame_err, above, w[11:0], (w[15:12] != 4'h0), (w[11:0] > thr));
            end
            checks++;
            if (a - g !== FRAME || r !== 16) begin
                errors++;
                $display("FAIL rand_timing[%0d]: latency=%0d rises=%0d required %0d/16", i, a - g, r, FRAME);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int g, a, r, l, s, n;
        logic [1:0] ak;
        do_reset();
        req = 2'b01;
        do_frame(16'h0555, g, a, ak, r, l, s);
        req = 2'b00;
        repeat (QUIET + 2) @(negedge clk);
        adc_word = 16'h0FFF;
        req = 2'b01;
        n = 0;
        while (cs !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cs !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_grant: cs=%b required 0", cs);
        end
        repeat (19) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cs !== 1'b1 || sck !== 1'b1 || ack !== 2'b00 || data !== 12'h000) begin
                errors++;
                $display("FAIL rst_mid_hold[%0d]: cs=%b sck=%b ack=%b data=%h required 1/1/00/000",
                         i, cs, sck, ack, data);
            end
            @(negedge clk);
        end
        rst_n = 1'b1;
        model_prefer = 1'b0;
        checks++;
        if (cs !== 1'b1 || sck !== 1'b1 || ack !== 2'b00 || data !== 12'h000) begin
            errors++;
            $display("FAIL rst_mid_release: cs=%b sck=%b ack=%b data=%h required 1/1/00/000",
                     cs, sck, ack, data);
        end
        do_frame(16'h0321, g, a, ak, r, l, s);
        req = 2'b00;
        checks++;
        if (s !== 0 || ak !== 2'b01 || owner !== 1'b0 || data !== 12'h321) begin
            errors++;
            $display("FAIL rst_mid_fresh: stray=%0d ack=%b owner=%b data=%h required 0/01/0/321",
                     s, ak, owner, data);
        end
        checks++;
        if (l !== FRAME || r !== 16 || a - g !== FRAME) begin
            errors++;
            $display("FAIL rst_mid_pins: cs_low=%0d rises=%0d latency=%0d required %0d/16/%0d",
                     l, r, a - g, FRAME, FRAME);
        end
    endtask

    initial begin : main
        test_reset();
        test_single();
        test_back_to_back();
        test_rr_pointer();
        test_frame_err();
        test_threshold();
        test_random();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adc_spi_scheduler.md
Name: adc_spi_scheduler

Overview:
Owns the serial ADC link (cs, sck, sdo) and shares it between two requesters. Each granted request runs one complete 16-bit conversion frame and returns the 12-bit sample to the winning requester. Sits between the ADC pins and the sample consumers, for example the LED/compare display path and a periodic logger. Arbitration is round-robin, and each sample is also compared against a threshold.

Parameters:
CLK_DIV, 2, sck half-period in clk cycles (>=1)
QUIET, 4, clk cycles cs stays high after a frame before the next grant (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  2  level request per requester; hold until matching ack
ack  out  2  one-cycle pulse to the granted requester when its data is valid
owner  out  1  index of the requester granted for the current or last frame
data  out  12  last sample (low 12 bits of the frame)
data_valid  out  1  one-cycle pulse, coincident with ack
frame_err  out  1  set when the frame's 4 leading bits are not zero; updated with data
threshold  in  12  compare value
above  out  1  data > threshold (unsigned, strict); updated with data
cs  out  1  ADC chip select, active low
sck  out  1  serial clock, idle high
sdo  in  1  serial data from the ADC, changes after falling sck

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Outputs: cs=1, sck=1, ack=0, data_valid=0, data=0, frame_err=0, above=0, owner=0.
  - State goes to IDLE.
  - Round-robin pointer favours requester 0.
  - A frame in progress is abandoned; no ack is issued for it.
- States: IDLE, SETUP, SHIFT, HOLD.
- IDLE:
  - req is sampled only in IDLE.
  - One bit set: grant that requester.
  - Both bits set: grant the requester not granted last (requester 0 first after reset).
  - On the grant edge E0: owner updates, cs goes to 0, state goes to SETUP.
- SETUP:
  - Lasts CLK_DIV cycles with sck=1.
  - At E0+CLK_DIV, sck goes to 0 and state goes to SHIFT.
- SHIFT:
  - sck toggles every CLK_DIV cycles, at E0+k*CLK_DIV for k=1..32.
  - sdo is sampled on the clk edge where sck goes 0->1 (k even), MSB first, into a 16-bit shift register.
  - After the 16th rising edge (k=32), sck stays 1.
- Frame end, at E0+33*CLK_DIV:
  - cs goes to 1.
  - data = shift[11:0]; frame_err = (shift[15:12] != 0); above = (shift[11:0] > threshold).
  - ack[owner] and data_valid pulse for exactly one cycle.
  - State goes to HOLD.
- HOLD:
  - Lasts QUIET cycles with cs=1 and sck=1, then IDLE.
  - Earliest next grant edge is E0+33*CLK_DIV+QUIET.
- Request handling:
  - A requester that drops req mid-frame still receives its ack; the frame always completes.
  - req changes outside IDLE are ignored.
- Pins during IDLE and HOLD: cs is high and sck is high; exactly 16 sck rising edges occur per frame.
- data, frame_err and above hold their values between frames.
- threshold is sampled at the frame-end edge only.

Test Plan:
1. CLK_DIV=2, QUIET=4; ADC model shifts 16'h0ABC; pulse req=2'b01 once.
   - Grant at E0; ack=2'b01 and data_valid one cycle after edge E0+66.
   - data=12'hABC, frame_err=0, owner=0.
   - cs low for exactly 66 cycles; 16 sck rising edges.
2. req=2'b11 held from reset.
   - Grants alternate 0,1,0,1.
   - Successive grant edges are 70 cycles apart (66+QUIET).
   - ack bits alternate 2'b01, 2'b10.
3. req=2'b10 for one frame, then req=2'b11.
   - Next grant goes to requester 0 (last grant was 1).
4. ADC frame 16'hF123.
   - data=12'h123, frame_err=1.
   - The following frame 16'h0123 clears frame_err to 0.
5. threshold=12'h800.
   - Frame 0x0801 gives above=1.
   - Frame 0x0800 gives above=0.
   - Changing threshold between frames does not change above until the next frame.
6. rst_n=0 at E0+20 (mid SHIFT), released 3 cycles later with req=2'b01 still high.
   - During and after reset: cs=1, sck=1, ack=0, data=0.
   - A fresh frame starts from IDLE and completes normally with no truncated ack.
